unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch stage and its data-memory stage. Data accesses have priority. A starvation counter guarantees that fetch is eventually served.
- Holds each requester stalled until its access completes.
- Drives a req/ack handshake toward a variable-latency memory.
- Sits between the fetch/memory stages and the backing memory. Its stall outputs feed the pipeline's stall/enable logic next to the hazard unit's stall.

Parameters:
STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting before fetch is forced to win
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock; everything is on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch requests a read
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle pulse: if_rdata is valid
if_stall  out  1  fetch must hold its request
dm_req  in  1  data access request
dm_we  in  1  1 = store, 0 = load
dm_ctrl  in  3  access size/sign, same encoding as the pipeline's DMCtrl
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data
dm_valid  out  1  one-cycle pulse: data access complete
dm_stall  out  1  memory stage must hold its request
mem_req  out  1  request to memory
mem_we  out  1  write enable
mem_ctrl  out  3  size/sign
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid when mem_ack=1
mem_ack  in  1  one-cycle completion pulse from memory

Behaviour:
- State machine states: IDLE, GNT_IF, GNT_DM.
- Reset values (rst=1 at a clock edge):
  - state=IDLE, starve_cnt=0.
  - All mem_* outputs are 0.
  - if_valid=dm_valid=0, if_rdata=dm_rdata=0.
- Eligibility in IDLE:
  - A port is eligible when its req=1 and its valid=0 in the same cycle.
  - The valid-pulse cycle consumes the request, so a held request is never re-granted.
- Grant decision in IDLE:
  - DM is chosen if eligible, unless IF is also eligible and starve_cnt==STARVE_MAX.
  - Otherwise IF is chosen if eligible.
  - Otherwise the block stays in IDLE.
- On a grant:
  - The granted port's attributes are latched into the mem_* registers; IF grants use we=0 and ctrl=word.
  - mem_req=1 from the next cycle, i.e. mem_* outputs are registered.
- Starvation counter:
  - A DM grant made while IF is eligible increments starve_cnt, saturating at STARVE_MAX.
  - An IF grant clears starve_cnt to 0.
  - A DM grant made while IF is not eligible leaves starve_cnt unchanged.
- GNT_x:
  - mem_req and all mem_* outputs are held stable until mem_ack=1.
  - On the mem_ack cycle: mem_rdata is captured into x_rdata (0 for stores), x_valid is set for the next cycle only, mem_req returns to 0 at the edge, and state goes to IDLE.
- Latency with the request at cycle 0 and memory latency L (ack L cycles after mem_req rises):
  - mem_req=1 at cycle 1.
  - ack at cycle 1+L.
  - x_valid at cycle 2+L.
- Stall outputs:
  - if_stall = if_req & ~if_valid; dm_stall = dm_req & ~dm_valid.
  - Both are combinational.
  - Requesters hold req and attributes stable while stalled.
- Back-to-back requests: the x_valid cycle coincides with IDLE. A new request becomes eligible the cycle after x_valid.
- Simultaneous if_req and dm_req in IDLE: resolved by the grant rule above. The loser stays stalled.
- Spurious acks: mem_ack in IDLE is ignored, including acks left over from a transaction abandoned by reset.
- Request dropped while granted: the in-flight access completes and the valid pulse is still issued.
- Reset mid-transaction: the transaction is abandoned, mem_req is 0 from the reset edge, and no valid pulse is generated.

Decomposition:
- Package mem_arb_pkg:
  - state enum: IDLE, GNT_IF, GNT_DM.
  - port-id enum: PORT_IF, PORT_DM.
  - DMCTRL_* size/sign constants, shared with the data-memory/control unit.
- Sub-module mem_arb_pick: combinational eligibility and grant choice plus the registered starvation counter. The FSM and datapath registers stay in the top module.

Test Plan:
- Single fetch, L=2:
  - Stimulus: if_req=1, if_addr=0x10 at cycle 0; memory returns 0x00500093.
  - Required response: mem_req rises at cycle 1; ack at cycle 3; if_valid=1 with if_rdata=0x00500093 at cycle 4; if_stall=1 for cycles 0-3.
- Simultaneous requests:
  - Stimulus: if_req and dm_req (load, addr 0x100) both at cycle 0.
  - Required response: DM is granted first; IF is granted in the IDLE cycle after dm_valid; both return correct data.
- Starvation, STARVE_MAX=4:
  - Stimulus: dm_req held high with a new load every completion; if_req held high.
  - Required response: exactly 4 DM grants, then an IF grant; starve_cnt reads 0 after it.
- Store:
  - Stimulus: dm_we=1, dm_ctrl=word, addr 0x20, wdata 0xDEADBEEF.
  - Required response: mem_we=1 and mem_wdata=0xDEADBEEF stable until ack; dm_valid pulse with dm_rdata=0.
- Reset mid-transaction:
  - Stimulus: rst pulsed at cycle 2 of a GNT_IF with L=5; the late mem_ack then arrives.
  - Required response: mem_req=0 from the reset edge; the late mem_ack is ignored; no if_valid; all outputs match reset values.
- Zero-wait memory (ack in the same cycle mem_req rises):
  - Stimulus: back-to-back fetch requests against a memory that acks immediately.
  - Required response: a 3-cycle request-to-request cadence with no duplicate grant of a held request.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle, or a memory access in flight for one port.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_IF = 2'b01,
    GNT_DM = 2'b10
  } arb_state_e;

  // Requesting port identity.
  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } arb_port_e;

  // Access size/sign encoding, identical to the pipeline's DMCtrl field.
  localparam logic [2:0] DMCTRL_WORD   = 3'b000;
  localparam logic [2:0] DMCTRL_HALF   = 3'b001;
  localparam logic [2:0] DMCTRL_HALF_U = 3'b010;
  localparam logic [2:0] DMCTRL_BYTE   = 3'b011;
  localparam logic [2:0] DMCTRL_BYTE_U = 3'b100;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection for the unified memory arbiter: decides which port wins
// in IDLE and tracks how long fetch has been passed over by data accesses.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_idle,
  input  logic      i_if_req,
  input  logic      i_if_valid,
  input  logic      i_dm_req,
  input  logic      i_dm_valid,
  output logic      o_grant,
  output arb_port_e o_grant_port
);

  localparam int CNT_W = cnt_width(STARVE_MAX);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic             w_if_elig;
  logic             w_dm_elig;
  logic             w_at_limit;
  logic [CNT_W-1:0] r_starve_cnt;

  // A request seen in its own valid-pulse cycle is already consumed.
  assign w_if_elig  = i_if_req & ~i_if_valid;
  assign w_dm_elig  = i_dm_req & ~i_dm_valid;
  assign w_at_limit = (r_starve_cnt == STARVE_LIM);

  // Data wins unless fetch has waited through STARVE_MAX data grants.
  always_comb begin
    o_grant      = 1'b0;
    o_grant_port = PORT_IF;
    if (!i_idle) begin
      o_grant = 1'b0;
    end else if (w_dm_elig && !(w_if_elig && w_at_limit)) begin
      o_grant      = 1'b1;
      o_grant_port = PORT_DM;
    end else if (w_if_elig) begin
      o_grant      = 1'b1;
      o_grant_port = PORT_IF;
    end else begin
      o_grant = 1'b0;
    end
  end

  // Count data grants that bypass a waiting fetch; a fetch grant clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= {CNT_W{1'b0}};
    end else if (o_grant) begin
      if (o_grant_port == PORT_IF) begin
        r_starve_cnt <= {CNT_W{1'b0}};
      end else if (w_if_elig && !w_at_limit) begin
        r_starve_cnt <= r_starve_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and the data
// memory stage. Data has priority; a starvation limit guarantees fetch
// progress. Each access is a registered req/ack exchange with the memory.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_ctrl,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              w_grant;
  arb_port_e         w_grant_port;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [2:0]        r_mem_ctrl;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_valid;
  logic              r_dm_valid;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk          (clk),
    .rst          (rst),
    .i_idle       (r_state == IDLE),
    .i_if_req     (if_req),
    .i_if_valid   (r_if_valid),
    .i_dm_req     (dm_req),
    .i_dm_valid   (r_dm_valid),
    .o_grant      (w_grant),
    .o_grant_port (w_grant_port)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave IDLE on a grant, return on the memory ack.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = (w_grant_port == PORT_DM) ? GNT_DM : GNT_IF;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      GNT_IF: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT_IF;
        end
      end
      GNT_DM: begin
        if (mem_ack) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = GNT_DM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory request registers, read-data capture and one-cycle valid pulses.
  // Acks outside a granted state (e.g. left over from a reset) are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_ctrl  <= 3'b000;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_if_rdata  <= {DATA_W{1'b0}};
      r_dm_rdata  <= {DATA_W{1'b0}};
      r_if_valid  <= 1'b0;
      r_dm_valid  <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_mem_req <= 1'b1;
            if (w_grant_port == PORT_DM) begin
              r_mem_we    <= dm_we;
              r_mem_ctrl  <= dm_ctrl;
              r_mem_addr  <= dm_addr;
              r_mem_wdata <= dm_wdata;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_ctrl  <= DMCTRL_WORD;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= {DATA_W{1'b0}};
            end
          end
        end
        GNT_IF: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_if_rdata <= mem_rdata;
            r_if_valid <= 1'b1;
          end
        end
        GNT_DM: begin
          if (mem_ack) begin
            r_mem_req  <= 1'b0;
            r_dm_rdata <= r_mem_we ? {DATA_W{1'b0}} : mem_rdata;
            r_dm_valid <= 1'b1;
          end
        end
        default: r_mem_req <= 1'b0;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_ctrl  = r_mem_ctrl;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_valid  = r_dm_valid;

  // A requester stalls until its valid pulse.
  assign if_stall = if_req & ~r_if_valid;
  assign dm_stall = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a table of single accesses
// plus hand-written multi-cycle sequences, against a variable-latency memory.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_valid, dm_stall;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [2:0]  mem_ctrl;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state
  int          mem_lat = 2;
  int          spur_req = 0;
  int          spur_done = 0;
  bit          resp_busy = 1'b0;
  int          resp_wait = 0;
  logic [31:0] resp_addr;
  logic        resp_we;
  logic [31:0] grant_log[$];

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  unified_mem_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_ctrl(dm_ctrl), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ctrl(mem_ctrl),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h0050_0093;
    else return {a[15:0], 16'hC0DE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory: ack mem_lat cycles after a new request; stores return garbage
  // read data so the arbiter's zeroing is visible.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_req && !resp_busy) begin
        resp_busy = 1'b1;
        resp_wait = mem_lat;
        resp_addr = mem_addr;
        resp_we   = mem_we;
        grant_log.push_back(mem_addr);
      end
      if (resp_busy) begin
        if (resp_wait == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = resp_we ? 32'hBADC_0FFE : mem_model(resp_addr);
          resp_busy = 1'b0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'h0;
          resp_wait--;
        end
      end else if (spur_req != spur_done) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_5A5A;
        spur_done = spur_req;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
      end
    end
  end

  // One table entry: request at cycle 0, check attributes, latency, data.
  task automatic run_vec(input vec_t v, input int idx);
    int  vcyc;
    int  bad_hold;
    int  bad_stall;
    logic vld;
    vcyc = -1; bad_hold = 0; bad_stall = 0;
    mem_lat = v.lat;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_ctrl = v.ctrl; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    check($sformatf("vec%0d_stall_c0", idx), v.is_dm ? dm_stall : if_stall, 64'd1);
    for (int c = 1; c <= 12 && vcyc < 0; c++) begin
      @(negedge clk);
      vld = v.is_dm ? dm_valid : if_valid;
      if (c == 1) check($sformatf("vec%0d_mem_req_c1", idx), mem_req, 64'd1);
      if (vld) begin
        vcyc = c;
        check($sformatf("vec%0d_rdata", idx), v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
        check($sformatf("vec%0d_stall_at_valid", idx), v.is_dm ? dm_stall : if_stall, 64'd0);
        if (v.is_dm) dm_req = 1'b0; else if_req = 1'b0;
      end else begin
        if ((v.is_dm ? dm_stall : if_stall) !== 1'b1) bad_stall++;
        if (mem_req !== 1'b1 || mem_we !== v.we || mem_ctrl !== v.exp_ctrl ||
            mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata)) bad_hold++;
      end
    end
    check($sformatf("vec%0d_valid_cycle", idx), vcyc, 2 + v.lat);
    check($sformatf("vec%0d_attr_hold_errs", idx), bad_hold, 64'd0);
    check($sformatf("vec%0d_stall_errs", idx), bad_stall, 64'd0);
    @(negedge clk);
    check($sformatf("vec%0d_valid_pulse_end", idx), {if_valid, dm_valid, mem_req}, 64'd0);
  endtask

  initial begin : main
    int base, dmc, ifc, nv, first, last, bad, reqc, seen;
    vecs[0] = '{1'b0, 1'b0, 3'b000, 32'h0000_0010, 32'h0,          2, 3'b000, 32'h0050_0093};
    vecs[1] = '{1'b1, 1'b0, 3'b000, 32'h0000_0100, 32'h0,          1, 3'b000, 32'h0100_C0DE};
    vecs[2] = '{1'b1, 1'b1, 3'b000, 32'h0000_0020, 32'hDEAD_BEEF,  3, 3'b000, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 3'b011, 32'h0000_0044, 32'h0,          0, 3'b011, 32'h0044_C0DE};
    vecs[4] = '{1'b0, 1'b0, 3'b000, 32'h0000_0200, 32'h0,          0, 3'b000, 32'h0200_C0DE};
    vecs[5] = '{1'b1, 1'b1, 3'b001, 32'h0000_0036, 32'h0000_1234,  4, 3'b001, 32'h0};

    rst = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_ctrl = 3'b000; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_mem", {mem_req, mem_we, mem_ctrl, mem_addr}, 64'd0);
    check("reset_wdata", mem_wdata, 64'd0);
    check("reset_valid", {if_valid, dm_valid, if_stall, dm_stall}, 64'd0);
    check("reset_rdata", {if_rdata, dm_rdata}, 64'd0);
    check("reset_starve", u_dut.u_pick.r_starve_cnt, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous fetch and load: data first, fetch in the dm_valid cycle.
    mem_lat = 1; base = grant_log.size(); dmc = -1; ifc = -1;
    if_req = 1'b1; if_addr = 32'h10;
    dm_req = 1'b1; dm_we = 1'b0; dm_ctrl = 3'b000; dm_addr = 32'h100;
    for (int c = 1; c <= 20 && (dmc < 0 || ifc < 0); c++) begin
      @(negedge clk);
      if (dm_valid && dmc < 0) begin
        dmc = c;
        check("sim_dm_rdata", dm_rdata, 32'h0100_C0DE);
        check("sim_if_still_stalled", if_stall, 64'd1);
        dm_req = 1'b0;
      end
      if (if_valid && ifc < 0) begin
        ifc = c;
        check("sim_if_rdata", if_rdata, 32'h0050_0093);
        if_req = 1'b0;
      end
    end
    check("sim_dm_cycle", dmc, 64'd3);
    check("sim_if_cycle", ifc, 64'd6);
    check("sim_grant_count", grant_log.size() - base, 64'd2);
    check("sim_first_grant", grant_log[base], 32'h100);
    check("sim_second_grant", grant_log[base + 1], 32'h10);
    @(negedge clk);

    // Starvation: fetch meets a data request in IDLE each round; it is
    // withdrawn while the data access is in flight so the race repeats.
    mem_lat = 0; base = grant_log.size();
    check("starve_init", u_dut.u_pick.r_starve_cnt, 64'd0);
    for (int r = 0; r < 5; r++) begin
      dm_req = 1'b1; dm_we = 1'b0; dm_ctrl = 3'b000; dm_addr = 32'h300 + 32'(4 * r);
      if_req = 1'b1; if_addr = 32'h400;
      @(negedge clk);
      if_req = 1'b0;
      seen = 0;
      for (int c = 2; c <= 10 && seen == 0; c++) begin
        @(negedge clk);
        if (dm_valid || if_valid) begin
          seen = 1;
          if (r < 4) begin
            check($sformatf("starve_r%0d_dm_wins", r), {dm_valid, if_valid}, 64'b10);
            check($sformatf("starve_r%0d_cnt", r), u_dut.u_pick.r_starve_cnt, r + 1);
          end else begin
            check("starve_if_forced", {dm_valid, if_valid}, 64'b01);
            check("starve_if_rdata", if_rdata, 32'h0400_C0DE);
            check("starve_cnt_cleared", u_dut.u_pick.r_starve_cnt, 64'd0);
          end
          dm_req = 1'b0;
        end
      end
      check($sformatf("starve_r%0d_completed", r), seen, 64'd1);
      @(negedge clk);
    end
    check("starve_grant_count", grant_log.size() - base, 64'd5);
    bad = 0;
    for (int k = 0; k < 4; k++) if (grant_log[base + k] !== 32'h300 + 32'(4 * k)) bad++;
    check("starve_dm_grants", bad, 64'd0);
    check("starve_fifth_is_if", grant_log[base + 4], 32'h400);

    // Reset two cycles into a long fetch; the late ack must be ignored.
    mem_lat = 5;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    check("rst_mid_req_c1", mem_req, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_zero", {mem_req, mem_we, mem_ctrl, mem_addr}, 64'd0);
    check("rst_mid_rdata_zero", {if_rdata, dm_rdata}, 64'd0);
    rst = 1'b0; if_req = 1'b0;
    seen = 0;
    for (int c = 4; c <= 12; c++) begin
      @(negedge clk);
      if (if_valid || dm_valid || mem_req) seen++;
    end
    check("rst_mid_late_ack_ignored", seen, 64'd0);
    check("rst_mid_outputs", {if_rdata, dm_rdata}, 64'd0);

    // Spurious ack while idle.
    spur_req++;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if_valid || dm_valid || mem_req) seen++;
    end
    check("spurious_ack_ignored", seen, 64'd0);

    // Zero-wait memory with a held fetch request: one grant every 3 cycles.
    mem_lat = 0; base = grant_log.size();
    nv = 0; first = -1; last = -1; bad = 0; reqc = 0;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (mem_req) reqc++;
      if (if_valid) begin
        if (last >= 0 && c - last != 3) bad++;
        if (first < 0) first = c;
        if (if_rdata !== 32'h0050_0093) bad++;
        last = c;
        nv++;
      end
    end
    if_req = 1'b0;
    check("zw_valid_count", nv, 64'd3);
    check("zw_first_valid", first, 64'd2);
    check("zw_cadence_errs", bad, 64'd0);
    check("zw_mem_req_cycles", reqc, 64'd3);
    check("zw_grant_count", grant_log.size() - base, 64'd3);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
